// File: rtl/scancode_dec.sv
// PS/2 set-2 scan-code decoder: strips E0/F0 prefixes, filters keyboard
// response bytes and queues {ext, brk, code} key events in a FWFT FIFO.
module scancode_dec #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       i_arst,
    input  logic       i_byte_en,
    input  logic [7:0] i_byte,
    input  logic       i_rd,
    output logic       o_valid,
    output logic [7:0] o_code,
    output logic       o_ext,
    output logic       o_brk,
    output logic       o_ovf,
    output logic       o_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1'b1);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXT    = 2'd1,
        ST_BRK    = 2'd2,
        ST_EXTBRK = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic             push_s;
    logic [9:0]       push_data_s;
    logic             err_s;
    logic             err_r;
    logic             ovf_r;

    logic [9:0]       mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW:0]      count_r;
    logic             pop_s;
    logic             full_s;
    logic             wr_en_s;
    logic             drop_s;

    // Keyboard responses (ACK, BAT, echo, resend, errors) never become events.
    function automatic logic is_filtered(input logic [7:0] b);
        logic hit;
        case (b)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: hit = 1'b1;
            default:                                        hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Prefix state register.
    always_ff @(posedge clk or posedge i_arst) begin
        if (i_arst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Prefix FSM: next state, event push and sequence-error detection.
    always_comb begin
        state_next_s = state_r;
        push_s       = 1'b0;
        push_data_s  = {2'b00, i_byte};
        err_s        = 1'b0;
        if (i_byte_en) begin
            case (state_r)
                ST_IDLE: begin
                    if (i_byte == 8'hE0) begin
                        state_next_s = ST_EXT;
                    end else if (i_byte == 8'hF0) begin
                        state_next_s = ST_BRK;
                    end else if (is_filtered(i_byte)) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        push_s       = 1'b1;
                        push_data_s  = {2'b00, i_byte};
                    end
                end
                ST_EXT: begin
                    if (i_byte == 8'hF0) begin
                        state_next_s = ST_EXTBRK;
                    end else if (i_byte == 8'hE0) begin
                        state_next_s = ST_EXT;
                    end else if (is_filtered(i_byte)) begin
                        err_s        = 1'b1;
                        state_next_s = ST_IDLE;
                    end else begin
                        push_s       = 1'b1;
                        push_data_s  = {2'b10, i_byte};
                        state_next_s = ST_IDLE;
                    end
                end
                ST_BRK, ST_EXTBRK: begin
                    state_next_s = ST_IDLE;
                    if ((i_byte == 8'hE0) || (i_byte == 8'hF0) || is_filtered(i_byte)) begin
                        err_s = 1'b1;
                    end else begin
                        push_s      = 1'b1;
                        push_data_s = {(state_r == ST_EXTBRK), 1'b1, i_byte};
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    assign full_s  = (count_r == CNT_FULL);
    assign pop_s   = i_rd && (count_r != {(PW+1){1'b0}});
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign wr_en_s = push_s && (!full_s || pop_s);
    assign drop_s  = push_s && full_s && !pop_s;

    // Event FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or posedge i_arst) begin
        if (i_arst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 10'd0;
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW+1){1'b0}};
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= push_data_s;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            if (wr_en_s && !pop_s) begin
                count_r <= count_r + CNT_ONE;
            end else if (pop_s && !wr_en_s) begin
                count_r <= count_r - CNT_ONE;
            end else begin
                count_r <= count_r;
            end
        end
    end

    // Registered status flags: one-cycle error pulse and sticky overflow.
    always_ff @(posedge clk or posedge i_arst) begin
        if (i_arst) begin
            err_r <= 1'b0;
            ovf_r <= 1'b0;
        end else begin
            err_r <= err_s;
            ovf_r <= ovf_r | drop_s;
        end
    end

    assign o_valid = (count_r != {(PW+1){1'b0}});
    assign o_ext   = mem_r[rd_ptr_r][9];
    assign o_brk   = mem_r[rd_ptr_r][8];
    assign o_code  = mem_r[rd_ptr_r][7:0];
    assign o_err   = err_r;
    assign o_ovf   = ovf_r;

endmodule

// File: tb/tb_scancode_dec.sv
// Scoreboard bench for scancode_dec: expected events are queued as bytes
// are driven and compared against the FIFO head as it is popped.
module tb_scancode_dec;

    localparam int DEPTH = 4;

    logic       clk;
    logic       i_arst;
    logic       i_byte_en;
    logic [7:0] i_byte;
    logic       i_rd;
    logic       o_valid;
    logic [7:0] o_code;
    logic       o_ext;
    logic       o_brk;
    logic       o_ovf;
    logic       o_err;

    int         checks_cnt;
    int         fail_cnt;
    logic [9:0] exp_q[$];
    logic       exp_ovf;

    scancode_dec #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .i_arst   (i_arst),
        .i_byte_en(i_byte_en),
        .i_byte   (i_byte),
        .i_rd     (i_rd),
        .o_valid  (o_valid),
        .o_code   (o_code),
        .o_ext    (o_ext),
        .o_brk    (o_brk),
        .o_ovf    (o_ovf),
        .o_err    (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one byte for one edge (caller is at a negedge); ev/x/b give the expected event.
    task automatic send(input logic [7:0] b, input logic ev, input logic x, input logic k,
                        input logic err);
        i_byte_en = 1'b1;
        i_byte    = b;
        if (ev) begin
            if (exp_q.size() < DEPTH) exp_q.push_back({x, k, b});
            else exp_ovf = 1'b1;
        end
        @(negedge clk);
        i_byte_en = 1'b0;
        check($sformatf("err_%02h", b), {31'd0, o_err}, {31'd0, err});
        check($sformatf("valid_%02h", b), {31'd0, o_valid}, {31'd0, (exp_q.size() != 0)});
        check($sformatf("ovf_%02h", b), {31'd0, o_ovf}, {31'd0, exp_ovf});
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            check("pop_valid", {31'd0, o_valid}, 32'd1);
            if (exp_q.size() != 0) begin
                check("pop_event", {22'd0, o_ext, o_brk, o_code}, {22'd0, exp_q.pop_front()});
            end else begin
                check("pop_underflow", 32'd0, 32'd1);
            end
            i_rd = 1'b1;
            @(negedge clk);
            i_rd = 1'b0;
        end
        check("drained_valid", {31'd0, o_valid}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_arst = 1'b1;
        #1;
        exp_q.delete();
        exp_ovf = 1'b0;
        check("rst_outs", {20'd0, o_valid, o_code, o_ext, o_brk, o_ovf, o_err}, 32'd0);
        @(negedge clk);
        i_arst = 1'b0;
    endtask

    initial begin
        checks_cnt = 0;
        fail_cnt   = 0;
        exp_ovf    = 1'b0;
        i_arst     = 1'b0;
        i_byte_en  = 1'b0;
        i_byte     = 8'h00;
        i_rd       = 1'b0;
        do_reset();

        // Make and break of a plain key.
        send(8'h1C, 1'b1, 1'b0, 1'b0, 1'b0);
        send(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'h1C, 1'b1, 1'b0, 1'b1, 1'b0);
        drain(2);

        // Extended make and extended break.
        send(8'hE0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'h75, 1'b1, 1'b1, 1'b0, 1'b0);
        send(8'hE0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'h75, 1'b1, 1'b1, 1'b1, 1'b0);
        drain(2);

        // Filtered bytes, repeated E0, then a sequence error.
        send(8'hFA, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'hE0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'hE0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'h6B, 1'b1, 1'b1, 1'b0, 1'b0);
        drain(1);
        send(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'hE0, 1'b0, 1'b0, 1'b0, 1'b1);
        send(8'hE1, 1'b1, 1'b0, 1'b0, 1'b0);
        send(8'hE0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'hFE, 1'b0, 1'b0, 1'b0, 1'b1);
        drain(1);

        // Overflow with back-to-back strobes.
        send(8'h15, 1'b1, 1'b0, 1'b0, 1'b0);
        send(8'h1D, 1'b1, 1'b0, 1'b0, 1'b0);
        send(8'h24, 1'b1, 1'b0, 1'b0, 1'b0);
        send(8'h2D, 1'b1, 1'b0, 1'b0, 1'b0);
        send(8'h2C, 1'b1, 1'b0, 1'b0, 1'b0);
        drain(4);

        // Pop on empty is ignored.
        i_rd = 1'b1;
        @(negedge clk);
        i_rd = 1'b0;
        check("empty_rd_valid", {31'd0, o_valid}, 32'd0);

        // Refill, then simultaneous push and pop while full.
        send(8'h31, 1'b1, 1'b0, 1'b0, 1'b0);
        send(8'h32, 1'b1, 1'b0, 1'b0, 1'b0);
        send(8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
        send(8'h34, 1'b1, 1'b0, 1'b0, 1'b0);
        check("full_head", {22'd0, o_ext, o_brk, o_code}, {22'd0, exp_q[0]});
        void'(exp_q.pop_front());
        exp_q.push_back({2'b00, 8'h3C});
        i_rd = 1'b1;
        send(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        i_rd = 1'b0;
        drain(4);

        // Reset in the middle of an extended sequence.
        send(8'hE0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_reset();
        send(8'h1C, 1'b1, 1'b0, 1'b0, 1'b0);
        drain(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/scancode_dec.md
# scancode_dec

PS/2 set-2 scan-code decoder sitting directly downstream of the PS/2 frame receiver. Consumes the receiver's validated-byte strobe and data byte, strips the `0xE0` (extended) and `0xF0` (break) prefixes, and filters keyboard response bytes. Each completed key code becomes one key event {ext, brk, code}, buffered in a small FIFO with a valid/read handshake toward the key-map/host logic.

## Interface
- DEPTH, 4: event FIFO entries; power of two, 2..16.
- clk  in  1  system clock; all logic on rising edge.
- i_arst  in  1  reset; one clock; reset is asynchronous and active-high.
- i_byte_en  in  1  one-cycle strobe: i_byte holds a received, parity-checked byte.
- i_byte  in  8  received byte; sampled only when i_byte_en=1.
- i_rd  in  1  consumer pop; effective only when o_valid=1.
- o_valid  out  1  FIFO non-empty; head event on o_code/o_ext/o_brk.
- o_code  out  8  head event key code (prefixes removed).
- o_ext  out  1  head event was `0xE0`-prefixed.
- o_brk  out  1  head event is a release (`0xF0`-prefixed).
- o_ovf  out  1  sticky: an event was dropped because the FIFO was full.
- o_err  out  1  one-cycle pulse: prefix sequence violated, partial sequence discarded.

## Operation
- Prefix FSM, 4 states, advances only on i_byte_en=1:
  - IDLE: `E0`→EXT; `F0`→BRK; filtered byte → stay IDLE, no event, no error; other → push {0,0,byte}, stay IDLE.
  - EXT: `F0`→EXTBRK; `E0`→stay EXT, no error; filtered → o_err, →IDLE; other → push {1,0,byte}, →IDLE.
  - BRK: `E0` or `F0` → o_err, →IDLE; filtered → o_err, →IDLE; other → push {0,1,byte}, →IDLE.
  - EXTBRK: `E0` or `F0` → o_err, →IDLE; filtered → o_err, →IDLE; other → push {1,1,byte}, →IDLE.
- Filtered bytes, never pushed: `00`, `AA`, `EE`, `FA`, `FC`, `FE`, `FF`.
- `E1` is not special; it is handled as an ordinary code.
- FIFO: DEPTH×10-bit memory {ext,brk,code}, wrapping read/write pointers, count 0..DEPTH.
  - Push on an FSM event; pop when i_rd && o_valid.
  - Full with push and pop in the same cycle: both happen and count is unchanged.
  - Full with push and no pop: the event is dropped, memory is untouched, o_ovf is set.
  - Empty with i_rd=1: ignored; pointers do not move.
- o_ovf stays set until reset.
- Reset mid-sequence (e.g. after `E0`): FSM returns to IDLE and the FIFO empties; the next plain code produces an ext=0 event.

## Timing
- Reset values: FSM=IDLE, pointers=0, count=0, memory cleared, o_valid=0, o_code=0, o_ext=0, o_brk=0, o_ovf=0, o_err=0.
- Latency: i_byte_en at rising edge N → o_valid=1 and the event on the outputs after edge N (1 cycle).
- Head is first-word-fall-through: o_code/o_ext/o_brk come straight from mem[rd_ptr]. After a pop at edge N, the next entry is presented after edge N.
- o_err is registered: high for exactly the cycle after the offending edge.
- o_ovf rises the cycle after the dropped push.
- i_byte_en may be high on consecutive cycles; each strobe is processed.

## Test plan
- Reset, then bytes `1C`, `F0`,`1C` → two events, {0,0,1C} then {0,1,1C}; o_err never pulses.
- `E0`,`75`,`E0`,`F0`,`75` → events {1,0,75} then {1,1,75}. Each appears one cycle after its last strobe.
- `FA`, `AA`, `E0`,`E0`,`6B` → filtered bytes are dropped and the repeated `E0` is absorbed; the only event is {1,0,6B}. Then `F0`,`E0` → o_err pulses one cycle, no event, and the FSM is in IDLE.
- DEPTH=4, i_rd=0, codes `15`,`1D`,`24`,`2D`,`2C` → 4 entries held and o_ovf=1. Pops return `15`,`1D`,`24`,`2D` and o_valid drops after the 4th. Then a push and pop in the same cycle while full keeps count=4.
- `E0` followed by i_arst → all outputs return to their reset values. Then `1C` → event {0,0,1C}.
